conv_feeder_6: RTL and testbench

- Upstream driver for the 6-channel convolution datapath (window/conv/relu/maxpool array).
- Per run, it loads 6×25 binary kernel bits serially into the conv instances, then asserts the conv start.
- It streams feature-map pixels for all 6 channels on each din_ready cycle, then zero-flushes until the conv array reports done.
- The layer (state 0: 28×28 input; state 1: 12×12 input) is selected per run.

---
 rtl/conv_pkg.sv | 16 +
 rtl/conv_feeder_6_if.sv | 37 +++
 rtl/conv_wload_seq.sv | 68 ++++++
 rtl/conv_feeder_6.sv | 113 +++++++++++
 tb/tb_conv_feeder_6.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and helpers for the 6-channel conv feeder.
package conv_pkg;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned TAPS     = 25;
  localparam int unsigned NPIX_L0  = 784;
  localparam int unsigned NPIX_L1  = 144;
  localparam int unsigned WBASE_L1 = 150;
  localparam int unsigned AW       = 10;
  localparam int unsigned CH       = 6;

  typedef enum logic [2:0] {IDLE, LOAD, PRIME, STREAM, FLUSH, DONE} state_t;

  function automatic logic [AW-1:0] npix_of(input logic layer);
    return layer ? AW'(NPIX_L1) : AW'(NPIX_L0);
  endfunction
endpackage

// File: rtl/conv_feeder_6_if.sv
// Bus between the conv feeder, its weight ROM / feature RAM and the conv array.
interface conv_feeder_6_if;
  import conv_pkg::*;

  logic                 go;
  logic                 layer;
  logic                 busy;
  logic                 done;
  logic [AW-1:0]        wt_addr;
  logic                 wt_bit;
  logic [AW-1:0]        fm_addr;
  logic [CH*DATA_W-1:0] fm_rdata;
  logic                 conv_state;
  logic                 conv_start;
  logic [CH-1:0]        weight_en;
  logic                 weight;
  logic [DATA_W-1:0]    din_0;
  logic [DATA_W-1:0]    din_1;
  logic [DATA_W-1:0]    din_2;
  logic [DATA_W-1:0]    din_3;
  logic [DATA_W-1:0]    din_4;
  logic [DATA_W-1:0]    din_5;
  logic                 din_ready;
  logic [CH-1:0]        conv_done;

  modport master (
    input  go, layer, wt_bit, fm_rdata, din_ready, conv_done,
    output busy, done, wt_addr, fm_addr, conv_state, conv_start,
           weight_en, weight, din_0, din_1, din_2, din_3, din_4, din_5
  );

  modport slave (
    output go, layer, wt_bit, fm_rdata, din_ready, conv_done,
    input  busy, done, wt_addr, fm_addr, conv_state, conv_start,
           weight_en, weight, din_0, din_1, din_2, din_3, din_4, din_5
  );
endinterface

// File: rtl/conv_wload_seq.sv
// Kernel-bit loader: walks ch 0..5 x tap 0..24 over the weight ROM and emits a
// one-hot channel strobe one cycle after each read, matching the ROM latency.
module conv_wload_seq
  import conv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [AW-1:0] base_i,
  output logic [AW-1:0] wt_addr_o,
  output logic [CH-1:0] strobe_o,
  output logic          last_o
);
  logic          active_q, active_d;
  logic [2:0]    ch_q, ch_d;
  logic [4:0]    tap_q, tap_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CH-1:0] strobe_q, strobe_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      ch_q     <= '0;
      tap_q    <= '0;
      addr_q   <= '0;
      strobe_q <= '0;
    end else begin
      active_q <= active_d;
      ch_q     <= ch_d;
      tap_q    <= tap_d;
      addr_q   <= addr_d;
      strobe_q <= strobe_d;
    end
  end

  always_comb begin
    active_d = active_q;
    ch_d     = ch_q;
    tap_d    = tap_q;
    addr_d   = addr_q;
    strobe_d = '0;
    if (start_i) begin
      active_d = 1'b1;
      ch_d     = '0;
      tap_d    = '0;
      addr_d   = base_i;
    end else if (active_q) begin
      strobe_d = CH'(1) << ch_q;
      addr_d   = addr_q + 1'b1;
      if (tap_q == 5'(TAPS - 1)) begin
        tap_d = '0;
        if (ch_q == 3'(CH - 1)) begin
          active_d = 1'b0;
          ch_d     = '0;
        end else begin
          ch_d = ch_q + 3'd1;
        end
      end else begin
        tap_d = tap_q + 5'd1;
      end
    end
  end

  assign wt_addr_o = active_q ? addr_q : '0;
  assign strobe_o  = strobe_q;
  // Only the final strobe (channel 5) coincides with the read side having stopped.
  assign last_o    = strobe_q[CH-1] & ~active_q;
endmodule

// File: rtl/conv_feeder_6.sv
// Conv-array feeder: loads 6x25 kernel bits, then streams feature-map pixels
// for all channels on din_ready, zero-flushes and waits for all conv_done bits.
module conv_feeder_6
  import conv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  conv_feeder_6_if.master bus
);
  state_t        state_q, state_d;
  logic          layer_q, layer_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] fm_addr;
  logic [AW-1:0] next_addr;
  logic [AW-1:0] npix;
  logic [AW-1:0] wt_addr;
  logic [CH-1:0] strobe;
  logic          load_last;
  logic          seq_start;
  logic          strm;

  assign seq_start = (state_q == IDLE) & bus.go;
  assign npix      = npix_of(layer_q);

  conv_wload_seq u_wload (
    .clk       (clk),
    .rst       (rst),
    .start_i   (seq_start),
    .base_i    (bus.layer ? AW'(WBASE_L1) : '0),
    .wt_addr_o (wt_addr),
    .strobe_o  (strobe),
    .last_o    (load_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      layer_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Advance only on consumption, and never past the last pixel of the layer.
  assign next_addr = (bus.din_ready && ptr_q != npix - 1'b1) ? ptr_q + 1'b1 : ptr_q;

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    fm_addr = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.go) begin
          state_d = LOAD;
          layer_d = bus.layer;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (load_last) state_d = PRIME;
      end
      PRIME: begin
        ptr_d   = '0;
        cnt_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        fm_addr = next_addr;
        ptr_d   = next_addr;
        if (bus.din_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == npix) state_d = FLUSH;
        end
      end
      FLUSH: begin
        fm_addr = ptr_q;
        if (&bus.conv_done) state_d = DONE;
      end
      DONE: begin
        fm_addr = ptr_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign strm = (state_q == STREAM);

  assign bus.busy       = state_q inside {LOAD, PRIME, STREAM, FLUSH};
  assign bus.done       = (state_q == DONE);
  assign bus.conv_start = state_q inside {PRIME, STREAM, FLUSH};
  assign bus.conv_state = layer_q;
  assign bus.wt_addr    = wt_addr;
  assign bus.weight_en  = strobe;
  assign bus.weight     = (|strobe) & bus.wt_bit;
  assign bus.fm_addr    = fm_addr;

  assign bus.din_0 = strm ? bus.fm_rdata[0*DATA_W +: DATA_W] : '0;
  assign bus.din_1 = strm ? bus.fm_rdata[1*DATA_W +: DATA_W] : '0;
  assign bus.din_2 = strm ? bus.fm_rdata[2*DATA_W +: DATA_W] : '0;
  assign bus.din_3 = strm ? bus.fm_rdata[3*DATA_W +: DATA_W] : '0;
  assign bus.din_4 = strm ? bus.fm_rdata[4*DATA_W +: DATA_W] : '0;
  assign bus.din_5 = strm ? bus.fm_rdata[5*DATA_W +: DATA_W] : '0;
endmodule

// File: tb/tb_conv_feeder_6.sv
// Directed bench for conv_feeder_6 with behavioural weight ROM and feature RAM.
module tb_conv_feeder_6;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  conv_feeder_6_if bus();

  conv_feeder_6 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ROM: bit = (addr mod 3 == 0); RAM: channel k of pixel i = i + 5k; both 1-cycle registered reads.
  always @(posedge clk) begin
    bus.wt_bit <= (bus.wt_addr % 3 == 0);
    for (int k = 0; k < 6; k++)
      bus.fm_rdata[k*16 +: 16] <= 16'(bus.fm_addr) + 16'(5 * k);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_go(input logic lyr);
    bus.layer = lyr;
    bus.go    = 1'b1;
    step();
    bus.go = 1'b0;
    check("go_busy", 32'(bus.busy), 32'd1);
    check("go_conv_state", 32'(bus.conv_state), 32'(lyr));
    check("go_wt_addr", 32'(bus.wt_addr), lyr ? 32'd150 : 32'd0);
    check("go_weight_en", 32'(bus.weight_en), 32'd0);
  endtask

  task automatic load_check(input int base, input logic lyr);
    for (int i = 0; i < 150; i++) begin
      if (i == 3) begin
        bus.go    = 1'b1;
        bus.layer = ~lyr;
      end else begin
        bus.go = 1'b0;
      end
      step();
      check("weight_en", 32'(bus.weight_en), 32'd1 << (i / 25));
      check("weight", 32'(bus.weight), ((base + i) % 3 == 0) ? 32'd1 : 32'd0);
      check("load_conv_start", 32'(bus.conv_start), 32'd0);
      if (i < 149) check("wt_addr", 32'(bus.wt_addr), 32'(base + i + 1));
      else         check("wt_addr_end", 32'(bus.wt_addr), 32'd0);
    end
    bus.go = 1'b0;
    step();
    check("prime_conv_start", 32'(bus.conv_start), 32'd1);
    check("prime_weight_en", 32'(bus.weight_en), 32'd0);
    check("prime_fm_addr", 32'(bus.fm_addr), 32'd0);
    check("conv_state_held", 32'(bus.conv_state), 32'(lyr));
  endtask

  task automatic stream(input int npix, input bit always_rdy, input int stop_at);
    int e;
    int cyc;
    logic rdy;
    e   = 0;
    cyc = 0;
    while (e < stop_at && cyc < 4000) begin
      step();
      check("din_0", 32'(bus.din_0), 32'(e));
      check("din_5", 32'(bus.din_5), 32'(e + 25));
      check("stream_conv_start", 32'(bus.conv_start), 32'd1);
      rdy = always_rdy || (cyc % 3 == 0);
      bus.din_ready = rdy;
      #1;
      check("fm_addr", 32'(bus.fm_addr),
            rdy ? ((e + 1 < npix) ? 32'(e + 1) : 32'(npix - 1)) : 32'(e));
      if (rdy) e++;
      cyc++;
    end
    check("stream_count", 32'(e), 32'(stop_at));
  endtask

  initial begin
    bus.go        = 1'b0;
    bus.layer     = 1'b0;
    bus.din_ready = 1'b0;
    bus.conv_done = '0;
    repeat (3) step();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_wt_addr", 32'(bus.wt_addr), 32'd0);
    check("rst_fm_addr", 32'(bus.fm_addr), 32'd0);
    check("rst_weight_en", 32'(bus.weight_en), 32'd0);
    check("rst_weight", 32'(bus.weight), 32'd0);
    check("rst_conv_start", 32'(bus.conv_start), 32'd0);
    check("rst_conv_state", 32'(bus.conv_state), 32'd0);
    check("rst_din_0", 32'(bus.din_0), 32'd0);
    rst = 1'b0;
    step();

    // Layer 0, din_ready 1,0,0 pattern, partial conv_done before full
    do_go(1'b0);
    load_check(0, 1'b0);
    stream(784, 1'b0, 784);
    step();
    bus.din_ready = 1'b0;
    check("flush_din_0", 32'(bus.din_0), 32'd0);
    check("flush_din_3", 32'(bus.din_3), 32'd0);
    check("flush_fm_addr", 32'(bus.fm_addr), 32'd783);
    check("flush_conv_start", 32'(bus.conv_start), 32'd1);
    check("flush_busy", 32'(bus.busy), 32'd1);
    bus.conv_done = 6'b011111;
    for (int i = 0; i < 20; i++) begin
      step();
      check("partial_done", 32'(bus.done), 32'd0);
      check("partial_busy", 32'(bus.busy), 32'd1);
    end
    bus.conv_done = 6'b111111;
    step();
    check("done_pulse", 32'(bus.done), 32'd1);
    check("done_busy", 32'(bus.busy), 32'd0);
    check("done_conv_start", 32'(bus.conv_start), 32'd0);
    bus.conv_done = '0;
    step();
    check("after_done", 32'(bus.done), 32'd0);
    check("after_busy", 32'(bus.busy), 32'd0);

    // Abort mid-stream with asynchronous reset at ptr 300
    do_go(1'b0);
    load_check(0, 1'b0);
    stream(784, 1'b1, 300);
    step();
    check("pre_abort_din_0", 32'(bus.din_0), 32'd300);
    bus.din_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_conv_start", 32'(bus.conv_start), 32'd0);
    check("abort_din_0", 32'(bus.din_0), 32'd0);
    check("abort_fm_addr", 32'(bus.fm_addr), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_abort_done", 32'(bus.done), 32'd0);
    check("post_abort_busy", 32'(bus.busy), 32'd0);

    // Layer 1 clean run, din_ready held high
    do_go(1'b1);
    load_check(150, 1'b1);
    stream(144, 1'b1, 144);
    step();
    bus.din_ready = 1'b0;
    check("l1_flush_din_0", 32'(bus.din_0), 32'd0);
    check("l1_flush_fm_addr", 32'(bus.fm_addr), 32'd143);
    check("l1_flush_busy", 32'(bus.busy), 32'd1);
    bus.conv_done = 6'b111111;
    step();
    check("l1_done", 32'(bus.done), 32'd1);
    bus.conv_done = '0;
    step();
    check("l1_after_done", 32'(bus.done), 32'd0);
    check("l1_conv_state", 32'(bus.conv_state), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
